// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS-subset core (ADD SUB AND OR SLT ADDI LW SW BEQ BNE J).
// One shared ALU, a single req/ready memory port, optional memory timeout,
// sticky fault halt and a wrapping retired-instruction counter.
module mips_multicycle_core #(
    parameter logic [31:0] RESET_PC    = 32'h0,
    parameter int          MEM_TIMEOUT = 0,
    parameter int          RETIRE_W    = 32
) (
    input  logic                clk,
    input  logic                reset,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [31:0]         mem_addr_o,
    output logic [31:0]         mem_wdata_o,
    input  logic [31:0]         mem_rdata_i,
    input  logic                mem_ready_i,
    output logic [31:0]         pc_o,
    output logic [RETIRE_W-1:0] retired_o,
    output logic                halted_o,
    output logic [1:0]          fault_code_o
);
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

    localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25, F_SLT = 6'h2A;

    state_t              state_q;
    logic [31:0]         pc_q, ir_q, a_q, b_q, alu_q, mdr_q, wait_q;
    logic [31:0]         rf_q [32];
    logic [RETIRE_W-1:0] retired_q;
    logic                halted_q;
    logic [1:0]          fault_q;

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, dst;
    logic [31:0] simm, alu_d;
    logic        legal, is_mem, timeout_hit;

    assign op     = ir_q[31:26];
    assign rs     = ir_q[25:21];
    assign rt     = ir_q[20:16];
    assign rd     = ir_q[15:11];
    assign funct  = ir_q[5:0];
    assign simm   = {{16{ir_q[15]}}, ir_q[15:0]};
    assign dst    = (op == OP_R) ? rd : rt;
    assign is_mem = (op == OP_LW) || (op == OP_SW);

    // Request is combinational from state so a fetch costs one cycle at zero wait;
    // gating with reset drops it the moment reset asserts.
    assign mem_req_o   = !reset && (state_q == S_FETCH || state_q == S_MEM);
    assign mem_we_o    = (state_q == S_MEM) && (op == OP_SW);
    assign mem_addr_o  = (state_q == S_MEM) ? alu_q : pc_q;
    assign mem_wdata_o = b_q;

    assign pc_o         = pc_q;
    assign retired_o    = retired_q;
    assign halted_o     = halted_q;
    assign fault_code_o = fault_q;

    // Limit hit on the wait cycle that would make the count reach MEM_TIMEOUT; ready wins.
    assign timeout_hit = (MEM_TIMEOUT > 0) && mem_req_o && !mem_ready_i &&
                         (wait_q == 32'(MEM_TIMEOUT - 1));

    // Shared ALU: R-type ops, otherwise address/immediate add.
    always_comb begin
        alu_d = a_q + simm;
        if (op == OP_R) begin
            case (funct)
                F_SUB:   alu_d = a_q - b_q;
                F_AND:   alu_d = a_q & b_q;
                F_OR:    alu_d = a_q | b_q;
                F_SLT:   alu_d = {31'b0, $signed(a_q) < $signed(b_q)};
                default: alu_d = a_q + b_q;
            endcase
        end
    end

    // Opcode/funct legality check used in DECODE.
    always_comb begin
        legal = 1'b0;
        case (op)
            OP_R: legal = (funct == F_ADD) || (funct == F_SUB) || (funct == F_AND) ||
                          (funct == F_OR)  || (funct == F_SLT);
            OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J: legal = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    // Main control FSM with datapath registers, register file and counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_q     <= '0;
            mdr_q     <= '0;
            wait_q    <= '0;
            retired_q <= '0;
            halted_q  <= 1'b0;
            fault_q   <= 2'd0;
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (mem_ready_i) begin
                        ir_q    <= mem_rdata_i;
                        pc_q    <= pc_q + 32'd4;
                        wait_q  <= '0;
                        state_q <= S_DECODE;
                    end else if (timeout_hit) begin
                        state_q  <= S_HALT;
                        halted_q <= 1'b1;
                        fault_q  <= 2'd3;
                    end else begin
                        wait_q <= wait_q + 32'd1;
                    end
                end
                S_DECODE: begin
                    a_q <= (rs == 5'd0) ? 32'd0 : rf_q[rs];
                    b_q <= (rt == 5'd0) ? 32'd0 : rf_q[rt];
                    if (!legal) begin
                        state_q  <= S_HALT;
                        halted_q <= 1'b1;
                        fault_q  <= 2'd1;
                    end else begin
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    alu_q <= alu_d;
                    if (is_mem) begin
                        if (alu_d[1:0] != 2'b00) begin
                            state_q  <= S_HALT;
                            halted_q <= 1'b1;
                            fault_q  <= 2'd2;
                        end else begin
                            state_q <= S_MEM;
                        end
                    end else if (op == OP_BEQ || op == OP_BNE) begin
                        if ((a_q == b_q) == (op == OP_BEQ)) pc_q <= pc_q + {simm[29:0], 2'b00};
                        retired_q <= retired_q + RETIRE_W'(1);
                        state_q   <= S_FETCH;
                    end else if (op == OP_J) begin
                        pc_q      <= {pc_q[31:28], ir_q[25:0], 2'b00};
                        retired_q <= retired_q + RETIRE_W'(1);
                        state_q   <= S_FETCH;
                    end else begin
                        state_q <= S_WB;
                    end
                end
                S_MEM: begin
                    if (mem_ready_i) begin
                        wait_q <= '0;
                        if (op == OP_SW) begin
                            retired_q <= retired_q + RETIRE_W'(1);
                            state_q   <= S_FETCH;
                        end else begin
                            mdr_q   <= mem_rdata_i;
                            state_q <= S_WB;
                        end
                    end else if (timeout_hit) begin
                        state_q  <= S_HALT;
                        halted_q <= 1'b1;
                        fault_q  <= 2'd3;
                    end else begin
                        wait_q <= wait_q + 32'd1;
                    end
                end
                S_WB: begin
                    if (dst != 5'd0) rf_q[dst] <= (op == OP_LW) ? mdr_q : alu_q;
                    retired_q <= retired_q + RETIRE_W'(1);
                    state_q   <= S_FETCH;
                end
                S_HALT:  state_q <= S_HALT;
                default: state_q <= S_HALT;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_multicycle_core.sv
// Scoreboard bench: an ISA-level model predicts every memory transaction
// (fetches, loads, stores) plus final pc/retired/fault; a monitor checks handshakes.
module tb_mips_multicycle_core;
    localparam logic [31:0] ILL = 32'hFC00_0000;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    logic        clk, reset;
    logic        mem_req_o, mem_we_o, mem_ready_i;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i, pc_o, retired_o;
    logic        halted_o;
    logic [1:0]  fault_code_o;

    mips_multicycle_core #(.RESET_PC(32'h0), .MEM_TIMEOUT(4), .RETIRE_W(32)) dut (
        .clk(clk), .reset(reset),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i),
        .pc_o(pc_o), .retired_o(retired_o), .halted_o(halted_o), .fault_code_o(fault_code_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0, errors = 0;
    txn_t        sb [$];
    logic [31:0] mem [256];
    int          exp_ret;
    logic [31:0] exp_pc;
    logic [1:0]  exp_fault;
    int          fixed_delay = 0;
    bit          hold_ready = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction
    function automatic logic [31:0] enc_r(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic [5:0] f);
        return {6'h00, rs, rt, rd, 5'd0, f};
    endfunction

    // ---------------- memory responder ----------------
    int wcnt, dly;
    bit in_req;
    always @(negedge clk) begin
        if (mem_ready_i) in_req = 0;
        mem_ready_i = 1'b0;
        mem_rdata_i = $urandom;
        if (reset || !mem_req_o) begin
            in_req = 0;
        end else if (!hold_ready) begin
            if (!in_req) begin
                in_req = 1;
                wcnt   = 0;
                dly    = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
            end
            if (wcnt >= dly) begin
                mem_ready_i = 1'b1;
                mem_rdata_i = mem[mem_addr_o[9:2]];
                if (mem_we_o) mem[mem_addr_o[9:2]] = mem_wdata_o;
            end else begin
                wcnt++;
            end
        end
    end

    // ---------------- monitor ----------------
    bit          prev_wait;
    logic        prev_we;
    logic [31:0] prev_addr, prev_wdata;
    always @(negedge clk) begin
        txn_t t;
        #1;
        if (!reset && mem_req_o) begin
            if (prev_wait) begin
                chk("stable_addr", mem_addr_o, prev_addr);
                chk("stable_we", 32'(mem_we_o), 32'(prev_we));
                if (prev_we) chk("stable_wdata", mem_wdata_o, prev_wdata);
            end
            if (mem_ready_i) begin
                if (sb.size() == 0) begin
                    chk("unexpected_req_addr", mem_addr_o, 32'hFFFF_FFFF);
                end else begin
                    t = sb.pop_front();
                    chk("hs_addr", mem_addr_o, t.addr);
                    chk("hs_we", 32'(mem_we_o), 32'(t.we));
                    if (t.we) chk("hs_wdata", mem_wdata_o, t.wdata);
                end
            end
            prev_wait  = !mem_ready_i;
            prev_addr  = mem_addr_o;
            prev_we    = mem_we_o;
            prev_wdata = mem_wdata_o;
        end else begin
            prev_wait = 0;
        end
    end

    // ---------------- ISA-level reference model ----------------
    task automatic run_model();
        logic [31:0] r [32];
        logic [31:0] m [256];
        logic [31:0] pc, ir, a, b, imm, ea, res;
        logic [4:0]  dst;
        bit          wr;
        txn_t        t;
        for (int i = 0; i < 32; i++) r[i] = 0;
        for (int i = 0; i < 256; i++) m[i] = mem[i];
        pc = 0; exp_ret = 0; exp_fault = 0;
        for (int step = 0; step < 2000; step++) begin
            ir = m[pc[9:2]];
            t.we = 0; t.addr = pc; t.wdata = 0;
            sb.push_back(t);
            pc  = pc + 4;
            a   = r[ir[25:21]];
            b   = r[ir[20:16]];
            imm = {{16{ir[15]}}, ir[15:0]};
            ea  = a + imm;
            wr  = 0; dst = ir[20:16]; res = 0;
            case (ir[31:26])
                6'h00: begin
                    wr = 1; dst = ir[15:11];
                    case (ir[5:0])
                        6'h20: res = a + b;
                        6'h22: res = a - b;
                        6'h24: res = a & b;
                        6'h25: res = a | b;
                        6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                        default: exp_fault = 1;
                    endcase
                end
                6'h08: begin wr = 1; res = ea; end
                6'h23: if (ea[1:0] != 0) exp_fault = 2;
                       else begin
                           t.we = 0; t.addr = ea; t.wdata = 0; sb.push_back(t);
                           wr = 1; res = m[ea[9:2]];
                       end
                6'h2B: if (ea[1:0] != 0) exp_fault = 2;
                       else begin
                           t.we = 1; t.addr = ea; t.wdata = b; sb.push_back(t);
                           m[ea[9:2]] = b;
                       end
                6'h04: if (a == b) pc = pc + (imm << 2);
                6'h05: if (a != b) pc = pc + (imm << 2);
                6'h02: pc = {pc[31:28], ir[25:0], 2'b00};
                default: exp_fault = 1;
            endcase
            if (exp_fault != 0) break;
            if (wr && dst != 0) r[dst] = res;
            exp_ret++;
        end
        exp_pc = pc;
    endtask

    // ---------------- helpers ----------------
    task automatic clear_mem();
        for (int i = 0; i < 64; i++) mem[i] = ILL;
        for (int i = 64; i < 256; i++) mem[i] = $urandom;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        hold_ready = 0;
        sb.delete();
        repeat (2) @(posedge clk);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic edges(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic finish_prog(string tag);
        int c;
        c = 0;
        while (!halted_o && c < 5000) begin
            @(posedge clk);
            #1;
            c++;
        end
        edges(2);
        chk({tag, "_halted"}, 32'(halted_o), 32'd1);
        chk({tag, "_fault"}, 32'(fault_code_o), 32'(exp_fault));
        chk({tag, "_retired"}, retired_o, 32'(exp_ret));
        chk({tag, "_pc"}, pc_o, exp_pc);
        chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
        chk({tag, "_req_low"}, 32'(mem_req_o), 32'd0);
    endtask

    task automatic gen_prog(int n);
        int          s;
        logic [4:0]  rs, rt, rd;
        logic [5:0]  f;
        clear_mem();
        for (int i = 0; i < n; i++) begin
            s  = $urandom_range(0, 9);
            rs = 5'($urandom_range(0, 7));
            rt = 5'($urandom_range(0, 7));
            rd = 5'($urandom_range(0, 7));
            case ($urandom_range(0, 4))
                0: f = 6'h20; 1: f = 6'h22; 2: f = 6'h24; 3: f = 6'h25;
                default: f = 6'h2A;
            endcase
            case (s)
                0, 1:    mem[i] = enc_i(6'h08, rs, rt, 16'($urandom));
                2, 3, 4: mem[i] = enc_r(rs, rt, rd, f);
                5:       mem[i] = enc_i(6'h23, 5'd0, rt, 16'(32'h100 + 4 * $urandom_range(0, 63)));
                6:       mem[i] = enc_i(6'h2B, 5'd0, rt, 16'(32'h100 + 4 * $urandom_range(0, 63)));
                7:       mem[i] = enc_i(6'h04, rs, rt, 16'($urandom_range(0, 3)));
                8:       mem[i] = enc_i(6'h05, rs, rt, 16'($urandom_range(0, 3)));
                default: mem[i] = {6'h02, 26'(i + 1 + int'($urandom_range(0, 3)))};
            endcase
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] ld_val;
        reset = 1'b1;
        mem_ready_i = 1'b0;
        mem_rdata_i = '0;
        clear_mem();
        do_reset();

        // reset state
        chk("rst_req", 32'(mem_req_o), 32'd0);
        chk("rst_we", 32'(mem_we_o), 32'd0);
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_retired", retired_o, 32'd0);
        chk("rst_halted", 32'(halted_o), 32'd0);
        chk("rst_fault", 32'(fault_code_o), 32'd0);

        // zero-wait ALU sequence: r5=5, r6=7, r7=r6+r5, store r7
        fixed_delay = 0;
        clear_mem();
        mem[0] = enc_i(6'h08, 5'd0, 5'd5, 16'd5);
        mem[1] = enc_i(6'h08, 5'd0, 5'd6, 16'd7);
        mem[2] = enc_r(5'd6, 5'd5, 5'd7, 6'h20);
        mem[3] = enc_i(6'h2B, 5'd0, 5'd7, 16'h0100);
        run_model();
        release_reset();
        edges(4);  chk("t1_ret_4cyc", retired_o, 32'd1);
        edges(4);  chk("t1_ret_8cyc", retired_o, 32'd2);
        edges(4);  chk("t1_ret_12cyc", retired_o, 32'd3);
        finish_prog("t1");
        chk("t1_stored_sum", mem[64], 32'd12);

        // three-cycle wait on every access: LW then SW of the loaded value
        do_reset();
        fixed_delay = 3;
        clear_mem();
        ld_val = mem[64];
        mem[0] = enc_i(6'h23, 5'd0, 5'd1, 16'h0100);
        mem[1] = enc_i(6'h2B, 5'd0, 5'd1, 16'h0104);
        run_model();
        release_reset();
        edges(10); chk("t2_ret_10cyc", retired_o, 32'd0);
        edges(1);  chk("t2_ret_11cyc", retired_o, 32'd1);
        finish_prog("t2");
        chk("t2_loaded_copy", mem[65], ld_val);

        // BEQ taken +2, BNE not taken
        do_reset();
        fixed_delay = 0;
        clear_mem();
        mem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd1);
        mem[1] = enc_i(6'h04, 5'd0, 5'd0, 16'd2);
        mem[4] = enc_i(6'h05, 5'd0, 5'd0, 16'd5);
        run_model();
        release_reset();
        edges(4);  chk("t3_pc_after_addi", pc_o, 32'h4);
        edges(3);  chk("t3_pc_after_beq", pc_o, 32'h10);
        chk("t3_ret_beq", retired_o, 32'd2);
        edges(3);  chk("t3_pc_after_bne", pc_o, 32'h14);
        chk("t3_ret_bne", retired_o, 32'd3);
        finish_prog("t3");

        // misaligned store
        do_reset();
        clear_mem();
        mem[0] = enc_i(6'h08, 5'd0, 5'd2, 16'd9);
        mem[1] = enc_i(6'h2B, 5'd0, 5'd2, 16'd3);
        run_model();
        release_reset();
        finish_prog("t4");
        chk("t4_code2", 32'(fault_code_o), 32'd2);
        chk("t4_ret1", retired_o, 32'd1);

        // timeout: ready never arrives during fetch
        do_reset();
        clear_mem();
        hold_ready = 1;
        release_reset();
        edges(3);  chk("t5_not_halted_3", 32'(halted_o), 32'd0);
        edges(1);  chk("t5_halted_4", 32'(halted_o), 32'd1);
        chk("t5_code3", 32'(fault_code_o), 32'd3);
        chk("t5_req_low", 32'(mem_req_o), 32'd0);
        chk("t5_ret0", retired_o, 32'd0);
        edges(2);  chk("t5_pc_frozen", pc_o, 32'h0);

        // reset during a MEM wait
        do_reset();
        fixed_delay = 0;
        clear_mem();
        mem[0] = enc_i(6'h23, 5'd0, 5'd1, 16'h0100);
        run_model();
        release_reset();
        edges(1);
        hold_ready = 1;
        edges(3);  chk("t6_req_waiting", 32'(mem_req_o), 32'd1);
        chk("t6_addr_mem", mem_addr_o, 32'h100);
        reset = 1'b1;
        #1 chk("t6_req_drop", 32'(mem_req_o), 32'd0);
        sb.delete();
        hold_ready = 0;
        release_reset();
        chk("t6_pc_reset", pc_o, 32'h0);
        chk("t6_ret_reset", retired_o, 32'd0);

        // randomized programs with random wait states
        fixed_delay = -1;
        for (int p = 0; p < 4; p++) begin
            do_reset();
            gen_prog(40);
            run_model();
            release_reset();
            finish_prog("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
